// File: rtl/rot_share_ctrl.sv
// Two-requester round-robin sequencer for a shared load/rotate-right shifter.
// Optional macro ROT_SHARE_LEFT_EN adds per-job rotate-left direction inputs.
module rot_share_ctrl #(
  parameter  int N  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_a,
  input  logic [N-1:0]  data_a,
  input  logic [AW-1:0] amt_a,
  input  logic          req_b,
  input  logic [N-1:0]  data_b,
  input  logic [AW-1:0] amt_b,
`ifdef ROT_SHARE_LEFT_EN
  input  logic          dir_a,
  input  logic          dir_b,
`endif
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          sh_load,
  output logic          sh_shift_ena,
  output logic [N-1:0]  sh_inp,
  input  logic [N-1:0]  sh_outp,
  output logic          busy,
  output logic          res_valid,
  output logic [N-1:0]  res_data,
  output logic          res_id
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t        state_reg, state_next;
  logic          last_gnt_reg, last_gnt_next;  // 0 = A, 1 = B
  logic          id_reg, id_next;
  logic [N-1:0]  data_reg, data_next;
  logic [AW-1:0] amt_reg, amt_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          pick_b;

  // Only reachable for non-power-of-2 N, where AW bits can exceed N-1.
  function automatic logic [AW-1:0] clamp_amt(input logic [AW-1:0] a);
    logic [AW:0] ext;
    ext = {1'b0, a};
    if (ext > (AW+1)'(N - 1))
      return AW'(N - 1);
    return a;
  endfunction

`ifdef ROT_SHARE_LEFT_EN
  // Rotating left by k equals rotating right by (N - k) mod N.
  function automatic logic [AW-1:0] eff_amt(input logic [AW-1:0] a, input logic dir);
    logic [AW-1:0] c;
    logic [AW:0]   diff;
    c    = clamp_amt(a);
    diff = (AW+1)'(N) - {1'b0, c};
    if (!dir || c == '0)
      return c;
    return diff[AW-1:0];
  endfunction
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      last_gnt_reg <= 1'b1;
      id_reg       <= 1'b0;
      data_reg     <= '0;
      amt_reg      <= '0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      id_reg       <= id_next;
      data_reg     <= data_next;
      amt_reg      <= amt_next;
      cnt_reg      <= cnt_next;
    end
  end

  // B wins when it is alone, or on contention when A was granted last.
  assign pick_b = req_b && (!req_a || !last_gnt_reg);

  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    id_next       = id_reg;
    data_next     = data_reg;
    amt_next      = amt_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_a || req_b) begin
          id_next   = pick_b;
          data_next = pick_b ? data_b : data_a;
`ifdef ROT_SHARE_LEFT_EN
          amt_next  = pick_b ? eff_amt(amt_b, dir_b) : eff_amt(amt_a, dir_a);
`else
          amt_next  = pick_b ? clamp_amt(amt_b) : clamp_amt(amt_a);
`endif
          if (req_a && req_b)
            last_gnt_next = pick_b;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_next   = amt_reg;
        state_next = (amt_reg != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == AW'(1))
          state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // All outputs decode from registered state so requests never reach them combinationally.
  assign busy         = (state_reg != S_IDLE);
  assign gnt_a        = (state_reg == S_LOAD) && !id_reg;
  assign gnt_b        = (state_reg == S_LOAD) && id_reg;
  assign sh_load      = (state_reg == S_LOAD);
  assign sh_shift_ena = (state_reg == S_LOAD) || (state_reg == S_SHIFT);
  assign sh_inp       = (state_reg == S_LOAD) ? data_reg : '0;
  assign res_valid    = (state_reg == S_DONE);
  assign res_data     = (state_reg == S_DONE) ? sh_outp : '0;
  assign res_id       = (state_reg == S_DONE) && id_reg;

endmodule
